// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR unit.
// Addresses, operation encoding, trap causes and status bit positions.
package csr_pkg;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRH  = 12'hB82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_t;

  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

endpackage

// File: rtl/csr_op_decode.sv
// Decodes SYSTEM-opcode CSR instructions into operation and write intent.
// Set/clear forms with a zero source field never write.
import csr_pkg::*;

module csr_op_decode (
  input  logic       stage_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [4:0] rs1_idx,
  output logic       is_csr,
  output csr_op_t    op,
  output logic       use_imm,
  output logic       wr_en,
  output logic       illegal_op
);

  // Pure combinational decode of func3 into op and write enable
  always_comb begin
    is_csr  = stage_valid && (opcode == OPC_SYSTEM) && (func3 != 3'b000);
    use_imm = func3[2];
    unique case (func3[1:0])
      2'b01:   op = OP_RW;
      2'b10:   op = OP_RS;
      2'b11:   op = OP_RC;
      default: op = OP_NONE;
    endcase
    illegal_op = is_csr && (op == OP_NONE);
    wr_en = is_csr && !illegal_op &&
            ((op == OP_RW) || (rs1_idx != 5'd0));
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file, counters and interrupt/mret trap controller.
// Outputs are combinational; all state updates land on the next edge.
import csr_pkg::*;

module csr_unit #(
  parameter int             DW          = 32,
  parameter int             ADDRW       = 12,
  parameter int             CNTW        = 64,
  parameter int             HART_ID     = 0,
  parameter logic [DW-1:0]  RESET_TVEC  = 32'h0000_0100,
  parameter bit             VECTORED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stage_valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [4:0]       rs1_idx,
  input  logic [ADDRW-1:0] csr_addr,
  input  logic [DW-1:0]    rs1_data,
  input  logic             is_mret,
  input  logic [DW-1:0]    pc_in,
  input  logic             ext_irq,
  input  logic             timer_irq,
  output logic [DW-1:0]    csr_rdata,
  output logic             illegal_csr,
  output logic             redirect,
  output logic [DW-1:0]    redirect_pc,
  output logic             irq_taken
);

  logic          is_csr, use_imm, wr_en, illegal_op;
  csr_op_t       op;
  logic          st_mie, st_mpie, mtie, meie, mtip, meip;
  logic [DW-1:0] mtvec, mscratch, mepc, mcause;
  logic [CNTW-1:0] mcycle, minstret;
  logic [DW-1:0] old, operand, wdata, vec_pc;
  logic          addr_ok, ro_addr, csr_ill, do_wr;
  logic          irq_take, mret_take;
  logic          mei_on, mti_on;
  logic [3:0]    cause;

  csr_op_decode u_dec (
    .stage_valid (stage_valid),
    .opcode      (opcode),
    .func3       (func3),
    .rs1_idx     (rs1_idx),
    .is_csr      (is_csr),
    .op          (op),
    .use_imm     (use_imm),
    .wr_en       (wr_en),
    .illegal_op  (illegal_op)
  );

  // Read mux: old value of the addressed CSR
  always_comb begin
    old     = '0;
    addr_ok = 1'b1;
    unique case (csr_addr)
      CSR_MSTATUS: begin
        old[MSTATUS_MIE]  = st_mie;
        old[MSTATUS_MPIE] = st_mpie;
      end
      CSR_MIE: begin
        old[MIP_MTIP] = mtie;
        old[MIP_MEIP] = meie;
      end
      CSR_MIP: begin
        old[MIP_MTIP] = mtip;
        old[MIP_MEIP] = meip;
      end
      CSR_MTVEC:    old = mtvec;
      CSR_MSCRATCH: old = mscratch;
      CSR_MEPC:     old = mepc;
      CSR_MCAUSE:   old = mcause;
      CSR_MCYCLE:   old = mcycle[DW-1:0];
      CSR_MCYCLEH:  old = mcycle[CNTW-1:DW];
      CSR_MINSTRET: old = minstret[DW-1:0];
      CSR_MINSTRH:  old = minstret[CNTW-1:DW];
      CSR_MHARTID:  old = DW'(HART_ID);
      default:      addr_ok = 1'b0;
    endcase
  end

  // Trap arbitration, write data and combinational outputs
  always_comb begin
    mei_on    = meip && meie;
    mti_on    = mtip && mtie;
    irq_take  = rst_n && stage_valid && st_mie && (mei_on || mti_on);
    cause     = mei_on ? CAUSE_MEI : CAUSE_MTI;
    mret_take = stage_valid && is_mret && !irq_take;
    ro_addr   = (csr_addr[ADDRW-1:ADDRW-2] == 2'b11) ||
                (csr_addr == CSR_MIP);
    csr_ill   = is_csr && !irq_take &&
                (illegal_op || !addr_ok || (wr_en && ro_addr));
    do_wr     = wr_en && !csr_ill && !irq_take;
    operand   = use_imm ? DW'(rs1_idx) : rs1_data;
    unique case (op)
      OP_RW:   wdata = operand;
      OP_RS:   wdata = old | operand;
      OP_RC:   wdata = old & ~operand;
      default: wdata = old;
    endcase
    vec_pc = {mtvec[DW-1:2], 2'b00};
    if (VECTORED_EN && (mtvec[1:0] == 2'b01))
      vec_pc = vec_pc + DW'({cause, 2'b00});
    csr_rdata   = (rst_n && is_csr && !csr_ill && !irq_take) ? old : '0;
    illegal_csr = rst_n && csr_ill;
    irq_taken   = irq_take;
    redirect    = rst_n && (irq_take || mret_take);
    redirect_pc = '0;
    if (rst_n && irq_take)
      redirect_pc = vec_pc;
    else if (rst_n && mret_take)
      redirect_pc = mepc;
  end

  // Status, enable, pending and trap CSR state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mtie     <= 1'b0;
      meie     <= 1'b0;
      mtip     <= 1'b0;
      meip     <= 1'b0;
      mtvec    <= RESET_TVEC;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      mtip <= timer_irq;
      meip <= ext_irq;
      if (irq_take) begin
        mepc    <= {pc_in[DW-1:2], 2'b00};
        mcause  <= {1'b1, (DW-1)'(cause)};
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret_take) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
      if (do_wr) begin
        unique case (csr_addr)
          CSR_MSTATUS: begin
            st_mie  <= wdata[MSTATUS_MIE];
            st_mpie <= wdata[MSTATUS_MPIE];
          end
          CSR_MIE: begin
            mtie <= wdata[MIP_MTIP];
            meie <= wdata[MIP_MEIP];
          end
          CSR_MTVEC: begin
            mtvec <= {wdata[DW-1:2],
                      (VECTORED_EN && (wdata[1:0] == 2'b01)) ?
                      2'b01 : 2'b00};
          end
          CSR_MSCRATCH: mscratch <= wdata;
          CSR_MEPC:     mepc <= {wdata[DW-1:2], 2'b00};
          CSR_MCAUSE:   mcause <= wdata;
          default: ;
        endcase
      end
    end
  end

  // 64-bit counters; a write to either half replaces that cycle's increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (do_wr && (csr_addr == CSR_MCYCLE))
        mcycle[DW-1:0] <= wdata;
      else if (do_wr && (csr_addr == CSR_MCYCLEH))
        mcycle[CNTW-1:DW] <= wdata;
      else
        mcycle <= mcycle + 1'b1;
      if (do_wr && (csr_addr == CSR_MINSTRET))
        minstret[DW-1:0] <= wdata;
      else if (do_wr && (csr_addr == CSR_MINSTRH))
        minstret[CNTW-1:DW] <= wdata;
      else if (stage_valid && !irq_take)
        minstret <= minstret + 1'b1;
    end
  end

endmodule
